// File: rtl/trax_pkg.sv
// Shared Trax protocol constants: ASCII codes, move-type encoding and move word layout.
// Used by both the receive-side parser and the transmit-side serializer.
package trax_pkg;

    localparam logic [7:0] CH_AT     = 8'd64;
    localparam logic [7:0] CH_Z      = 8'd90;
    localparam logic [7:0] CH_0      = 8'd48;
    localparam logic [7:0] CH_9      = 8'd57;
    localparam logic [7:0] CH_W      = 8'd87;
    localparam logic [7:0] CH_B      = 8'd66;
    localparam logic [7:0] CH_PLUS   = 8'd43;
    localparam logic [7:0] CH_BSLASH = 8'd92;
    localparam logic [7:0] CH_SLASH  = 8'd47;
    localparam logic [7:0] CH_NL     = 8'd10;

    localparam int MOVE_BITS   = 22;
    localparam int FIELD_W     = 10;
    localparam int MV_ROW_LSB  = 0;
    localparam int MV_COL_LSB  = 10;
    localparam int MV_TYPE_LSB = 20;

    typedef enum logic [1:0] {
        MT_PLUS   = 2'b00,
        MT_BSLASH = 2'b01,
        MT_SLASH  = 2'b10
    } move_type_e;

    typedef enum logic [2:0] {
        CL_LETTER,
        CL_DIGIT,
        CL_TYPE,
        CL_NL,
        CL_OTHER
    } char_class_e;

    typedef enum logic [2:0] {
        S_COLOR,
        S_IDLE,
        S_COL,
        S_ROW,
        S_TYPE,
        S_NL,
        S_RESYNC
    } parser_state_e;

    function automatic logic [MOVE_BITS-1:0] pack_move(input move_type_e t,
                                                       input logic [FIELD_W-1:0] col,
                                                       input logic [FIELD_W-1:0] row);
        logic [MOVE_BITS-1:0] w;
        w = '0;
        w[MV_TYPE_LSB +: 2]      = t;
        w[MV_COL_LSB +: FIELD_W] = col;
        w[MV_ROW_LSB +: FIELD_W] = row;
        return w;
    endfunction

endpackage

// File: rtl/trax_ascii_class.sv
// Combinational byte classifier: protocol character class plus the value carried
// by letters (byte-64), digits (byte-48) and move-type characters.
module trax_ascii_class
    import trax_pkg::*;
(
    input  logic [7:0]  byte_in,
    output char_class_e cls,
    output logic [4:0]  letter_val,
    output logic [3:0]  digit_val,
    output move_type_e  type_code
);

    // Values are only meaningful when cls selects the matching class.
    assign letter_val = 5'(byte_in - CH_AT);
    assign digit_val  = 4'(byte_in - CH_0);

    always_comb begin
        cls       = CL_OTHER;
        type_code = MT_PLUS;
        if (byte_in >= CH_AT && byte_in <= CH_Z) begin
            cls = CL_LETTER;
        end else if (byte_in >= CH_0 && byte_in <= CH_9) begin
            cls = CL_DIGIT;
        end else if (byte_in == CH_PLUS) begin
            cls       = CL_TYPE;
            type_code = MT_PLUS;
        end else if (byte_in == CH_BSLASH) begin
            cls       = CL_TYPE;
            type_code = MT_BSLASH;
        end else if (byte_in == CH_SLASH) begin
            cls       = CL_TYPE;
            type_code = MT_SLASH;
        end else if (byte_in == CH_NL) begin
            cls = CL_NL;
        end
    end

endmodule

// File: rtl/trax_move_parser.sv
// Receive-side Trax framing: turns UART bytes into {type, col, row} move words,
// latches the player colour and resynchronises on malformed lines.
module trax_move_parser
    import trax_pkg::*;
#(
    parameter int MOVE_W          = 22,
    parameter int MAX_ROW_DIGITS  = 3,
    parameter int MAX_COL_LETTERS = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_finish,
    input  logic              restart,
    output logic [MOVE_W-1:0] move_out,
    output logic              move_valid,
    output logic              color,
    output logic              color_valid,
    output logic              frame_err
);

    localparam logic [1:0] COL_LIM = 2'(MAX_COL_LETTERS);
    localparam logic [1:0] ROW_LIM = 2'(MAX_ROW_DIGITS);

    parser_state_e     state_q, state_d;
    logic              rx_finish_q, rx_finish_d;
    logic [FIELD_W-1:0] col_acc_q, col_acc_d;
    logic [FIELD_W-1:0] row_acc_q, row_acc_d;
    logic [1:0]        ncol_q, ncol_d;
    logic [1:0]        nrow_q, nrow_d;
    move_type_e        type_q, type_d;
    logic [MOVE_W-1:0] move_out_q, move_out_d;
    logic              move_valid_q, move_valid_d;
    logic              color_q, color_d;
    logic              color_valid_q, color_valid_d;
    logic              frame_err_q, frame_err_d;

    logic              acc;
    logic              err;
    char_class_e       cls;
    logic [4:0]        letter_val;
    logic [3:0]        digit_val;
    move_type_e        type_code;
    logic [FIELD_W-1:0] letter_ext, digit_ext, col_x26, row_x10;

    trax_ascii_class u_class (
        .byte_in    (rx_data),
        .cls        (cls),
        .letter_val (letter_val),
        .digit_val  (digit_val),
        .type_code  (type_code)
    );

    assign acc        = rx_finish & ~rx_finish_q;
    assign letter_ext = {5'd0, letter_val};
    assign digit_ext  = {6'd0, digit_val};
    assign col_x26    = (col_acc_q << 4) + (col_acc_q << 3) + (col_acc_q << 1);
    assign row_x10    = (row_acc_q << 3) + (row_acc_q << 1);

    always_comb begin
        state_d       = state_q;
        rx_finish_d   = rx_finish;
        col_acc_d     = col_acc_q;
        row_acc_d     = row_acc_q;
        ncol_d        = ncol_q;
        nrow_d        = nrow_q;
        type_d        = type_q;
        move_out_d    = move_out_q;
        move_valid_d  = 1'b0;
        color_d       = color_q;
        color_valid_d = color_valid_q;
        frame_err_d   = 1'b0;
        err           = 1'b0;

        if (restart) begin
            state_d       = S_COLOR;
            color_valid_d = 1'b0;
            col_acc_d     = '0;
            row_acc_d     = '0;
            ncol_d        = '0;
            nrow_d        = '0;
            type_d        = MT_PLUS;
        end else if (acc) begin
            case (state_q)
                S_COLOR: begin
                    if (rx_data == CH_W || rx_data == CH_B) begin
                        color_d       = (rx_data == CH_B);
                        color_valid_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (cls == CL_LETTER) begin
                        col_acc_d = letter_ext;
                        ncol_d    = 2'd1;
                        state_d   = S_COL;
                    end else if (cls != CL_NL) begin
                        err = 1'b1;
                    end
                end
                S_COL: begin
                    // '@' (value 0) is only legal as a lone column letter.
                    if (cls == CL_LETTER) begin
                        if (ncol_q < COL_LIM && col_acc_q != '0 && letter_val != 5'd0) begin
                            col_acc_d = col_x26 + letter_ext;
                            ncol_d    = ncol_q + 2'd1;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (cls == CL_DIGIT) begin
                        row_acc_d = digit_ext;
                        nrow_d    = 2'd1;
                        state_d   = S_ROW;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_ROW: begin
                    if (cls == CL_DIGIT && nrow_q < ROW_LIM) begin
                        row_acc_d = row_x10 + digit_ext;
                        nrow_d    = nrow_q + 2'd1;
                    end else if (cls == CL_TYPE) begin
                        type_d  = type_code;
                        state_d = S_NL;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_NL: begin
                    if (cls == CL_NL) begin
                        move_out_d   = MOVE_W'(pack_move(type_q, col_acc_q, row_acc_q));
                        move_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_RESYNC: begin
                    if (cls == CL_NL) begin
                        state_d = S_IDLE;
                    end
                end
                // The type byte is consumed in S_ROW; any other encoding recovers via resync.
                default: state_d = S_RESYNC;
            endcase

            if (err) begin
                frame_err_d = 1'b1;
                state_d     = S_RESYNC;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_COLOR;
            rx_finish_q   <= 1'b0;
            col_acc_q     <= '0;
            row_acc_q     <= '0;
            ncol_q        <= '0;
            nrow_q        <= '0;
            type_q        <= MT_PLUS;
            move_out_q    <= '0;
            move_valid_q  <= 1'b0;
            color_q       <= 1'b0;
            color_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_finish_q   <= rx_finish_d;
            col_acc_q     <= col_acc_d;
            row_acc_q     <= row_acc_d;
            ncol_q        <= ncol_d;
            nrow_q        <= nrow_d;
            type_q        <= type_d;
            move_out_q    <= move_out_d;
            move_valid_q  <= move_valid_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign move_out    = move_out_q;
    assign move_valid  = move_valid_q;
    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_trax_move_parser.sv
// Bench for trax_move_parser: directed protocol scenarios plus random frames,
// checked against a line-oriented model of the Trax receive grammar.
module tb_trax_move_parser;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_finish;
    logic        restart;
    logic [21:0] move_out;
    logic        move_valid;
    logic        color;
    logic        color_valid;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit          m_wait_color, m_color, m_color_valid, m_discard;
    logic [21:0] m_move;
    logic [7:0]  line_q[$];
    bit          e_mv, e_fe;

    // Observations of the last driven byte.
    logic [3:0]  obs_flags;
    logic [21:0] obs_move;
    logic [1:0]  obs_tail;

    always #5 clock = ~clock;

    trax_move_parser dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_finish   (rx_finish),
        .restart     (restart),
        .move_out    (move_out),
        .move_valid  (move_valid),
        .color       (color),
        .color_valid (color_valid),
        .frame_err   (frame_err)
    );

    // Directed strings use '|' for NL and '~' for the backslash move type.
    function automatic logic [7:0] xlat(input logic [7:0] b);
        if (b == 8'd124) return 8'd10;
        if (b == 8'd126) return 8'd92;
        return b;
    endfunction

    function automatic bit is_letter(input logic [7:0] b);
        return b >= 8'd64 && b <= 8'd90;
    endfunction

    function automatic bit is_digit(input logic [7:0] b);
        return b >= 8'd48 && b <= 8'd57;
    endfunction

    function automatic bit is_type(input logic [7:0] b);
        return b == 8'd43 || b == 8'd92 || b == 8'd47;
    endfunction

    // A line is letters{1,2} digits{1,3} type; '@' may only appear as a lone letter.
    function automatic bit line_ok(input bit need_complete);
        int i = 0;
        int nl = 0;
        int nd = 0;
        int nt = 0;
        int n = line_q.size();
        while (i < n && is_letter(line_q[i])) begin nl++; i++; end
        while (i < n && is_digit(line_q[i])) begin nd++; i++; end
        if (i < n && is_type(line_q[i])) begin nt = 1; i++; end
        if (i != n) return 1'b0;
        if (n > 0 && nl == 0) return 1'b0;
        if (nl > 2 || nd > 3) return 1'b0;
        if (nl == 2 && (line_q[0] == 8'd64 || line_q[1] == 8'd64)) return 1'b0;
        if (nt == 1 && nd == 0) return 1'b0;
        if (need_complete && (nl == 0 || nd == 0 || nt == 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [21:0] decode_line();
        int col = 0;
        int row = 0;
        logic [1:0] t = 2'b00;
        foreach (line_q[i]) begin
            if (is_letter(line_q[i]))     col = col * 26 + (int'(line_q[i]) - 64);
            else if (is_digit(line_q[i])) row = row * 10 + (int'(line_q[i]) - 48);
            else t = (line_q[i] == 8'd43) ? 2'b00 : (line_q[i] == 8'd92) ? 2'b01 : 2'b10;
        end
        return {t, col[9:0], row[9:0]};
    endfunction

    task automatic model_reset();
        m_wait_color = 1; m_color = 0; m_color_valid = 0; m_discard = 0;
        m_move = '0; line_q.delete(); e_mv = 0; e_fe = 0;
    endtask

    task automatic model_restart();
        m_wait_color = 1; m_color_valid = 0; m_discard = 0; line_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        e_mv = 0; e_fe = 0;
        if (m_wait_color) begin
            if (b == 8'd87 || b == 8'd66) begin
                m_color = (b == 8'd66); m_color_valid = 1; m_wait_color = 0;
            end
        end else if (m_discard) begin
            if (b == 8'd10) m_discard = 0;
        end else if (b == 8'd10) begin
            if (line_q.size() != 0) begin
                if (line_ok(1'b1)) begin
                    m_move = decode_line(); e_mv = 1;
                end else begin
                    e_fe = 1; m_discard = 1;
                end
                line_q.delete();
            end
        end else begin
            line_q.push_back(b);
            if (!line_ok(1'b0)) begin
                e_fe = 1; m_discard = 1; line_q.delete();
            end
        end
    endtask

    // One byte on one rx_finish pulse: accept edge, then a low cycle.
    task automatic drive_byte(input logic [7:0] b);
        model_byte(b);
        @(negedge clock);
        rx_data = b; rx_finish = 1'b1;
        @(posedge clock); #1;
        obs_flags = {move_valid, frame_err, color_valid, color};
        obs_move  = move_out;
        @(negedge clock);
        rx_finish = 1'b0; rx_data = 8'($urandom);
        @(posedge clock); #1;
        obs_tail = {move_valid, frame_err};
    endtask

    task automatic do_restart();
        @(negedge clock);
        restart = 1'b1;
        @(posedge clock); #1;
        obs_flags = {move_valid, frame_err, color_valid, color};
        obs_move  = move_out;
        @(negedge clock);
        restart = 1'b0;
        model_restart();
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_finish = 1'b0; restart = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({move_out, move_valid, color, color_valid, frame_err} !== 26'd0) begin
            bad++;
            $display("FAIL reset_values got=%h want=0", {move_out, move_valid, color, color_valid, frame_err});
        end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if ({move_out, move_valid, color, color_valid, frame_err} !== 26'd0) begin
            bad++;
            $display("FAIL after_release got=%h want=0", {move_out, move_valid, color, color_valid, frame_err});
        end
    endtask

    task automatic test_color();
        string s = "xA0|+B";
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(xlat(s[i]));
            total++;
            if ({obs_flags, obs_tail} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00}) begin
                bad++;
                $display("FAIL color byte=%h flags got=%b want=%b", s[i], {obs_flags, obs_tail},
                         {e_mv, e_fe, m_color_valid, m_color, 2'b00});
            end
        end
        s = "C12/|";
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(xlat(s[i]));
            total++;
            if ({obs_flags, obs_tail, obs_move} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00, m_move}) begin
                bad++;
                $display("FAIL first_move byte=%h got=%b/%h want=%b/%h", s[i], obs_flags, obs_move,
                         {e_mv, e_fe, m_color_valid, m_color}, m_move);
            end
        end
        total++;
        if (move_out !== {2'b10, 10'd3, 10'd12}) begin
            bad++;
            $display("FAIL move_C12 got=%h want=%h", move_out, {2'b10, 10'd3, 10'd12});
        end
    endtask

    task automatic test_frames();
        string s = "WAB999+|@0~|||ZZ999/|";
        do_restart();
        total++;
        if (obs_flags[1] !== 1'b0 || obs_move !== m_move) begin
            bad++;
            $display("FAIL restart_plain color_valid got=%b move got=%h want=%h", obs_flags[1], obs_move, m_move);
        end
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(xlat(s[i]));
            total++;
            if ({obs_flags, obs_tail, obs_move} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00, m_move}) begin
                bad++;
                $display("FAIL frames byte=%h got=%b/%h want=%b/%h", s[i], obs_flags, obs_move,
                         {e_mv, e_fe, m_color_valid, m_color}, m_move);
            end
            if (i == 7) begin
                total++;
                if (obs_move !== {2'b00, 10'd28, 10'd999}) begin
                    bad++;
                    $display("FAIL move_AB999 got=%h want=%h", obs_move, {2'b00, 10'd28, 10'd999});
                end
            end
        end
        total++;
        if (move_out !== {2'b10, 10'd702, 10'd999}) begin
            bad++;
            $display("FAIL move_ZZ999 got=%h want=%h", move_out, {2'b10, 10'd702, 10'd999});
        end
    endtask

    task automatic test_errors();
        string s = "ABC1+|D7+|A1234+|B2~|A5+X|C3/|A|E5+|F6+|@A1+|1|G8/|";
        int errs = 0;
        int moves = 0;
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(xlat(s[i]));
            errs  += int'(obs_flags[2]);
            moves += int'(obs_flags[3]);
            total++;
            if ({obs_flags, obs_tail, obs_move} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00, m_move}) begin
                bad++;
                $display("FAIL errors byte=%h got=%b/%h want=%b/%h", s[i], obs_flags, obs_move,
                         {e_mv, e_fe, m_color_valid, m_color}, m_move);
            end
        end
        total++;
        if (errs != 6 || moves != 5) begin
            bad++;
            $display("FAIL error_counts got=%0d/%0d want=6/5", errs, moves);
        end
    endtask

    task automatic test_level();
        string s = "3+|";
        model_byte(8'd90);
        @(negedge clock);
        rx_data = 8'd90; rx_finish = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            total++;
            if ({move_valid, frame_err} !== 2'b00) begin
                bad++;
                $display("FAIL level_hold cycle=%0d got=%b want=00", c, {move_valid, frame_err});
            end
        end
        @(negedge clock); rx_finish = 1'b0;
        @(posedge clock);
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(xlat(s[i]));
            total++;
            if ({obs_flags, obs_tail, obs_move} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00, m_move}) begin
                bad++;
                $display("FAIL level byte=%h got=%b/%h want=%b/%h", s[i], obs_flags, obs_move,
                         {e_mv, e_fe, m_color_valid, m_color}, m_move);
            end
        end
        total++;
        if (move_out !== {2'b00, 10'd26, 10'd3}) begin
            bad++;
            $display("FAIL level_single_accept got=%h want=%h", move_out, {2'b00, 10'd26, 10'd3});
        end
    endtask

    task automatic test_restart();
        string s = "AAWB1+|";
        drive_byte(8'd65);
        @(negedge clock);
        rx_data = 8'd87; rx_finish = 1'b1; restart = 1'b1;
        @(posedge clock); #1;
        total++;
        if ({move_valid, frame_err, color_valid} !== 3'b000 || move_out !== m_move) begin
            bad++;
            $display("FAIL restart_with_accept got=%b/%h want=000/%h", {move_valid, frame_err, color_valid},
                     move_out, m_move);
        end
        @(negedge clock);
        restart = 1'b0; rx_finish = 1'b0;
        model_restart();
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(xlat(s[i]));
            total++;
            if ({obs_flags, obs_tail, obs_move} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00, m_move}) begin
                bad++;
                $display("FAIL restart byte=%h got=%b/%h want=%b/%h", s[i], obs_flags, obs_move,
                         {e_mv, e_fe, m_color_valid, m_color}, m_move);
            end
        end
        total++;
        if (move_out !== {2'b00, 10'd2, 10'd1} || color !== 1'b0) begin
            bad++;
            $display("FAIL restart_recover got=%h/%b want=%h/0", move_out, color, {2'b00, 10'd2, 10'd1});
        end
    endtask

    task automatic test_random();
        logic [7:0] frm[$];
        logic [7:0] v;
        int pos;
        for (int f = 0; f < 60; f++) begin
            frm.delete();
            begin
                int nl = $urandom_range(1, 2);
                int nd = $urandom_range(1, 3);
                for (int k = 0; k < nl; k++)
                    frm.push_back((nl == 1 && $urandom_range(0, 7) == 0) ? 8'd64 : 8'($urandom_range(65, 90)));
                for (int k = 0; k < nd; k++) frm.push_back(8'($urandom_range(48, 57)));
                case ($urandom_range(0, 2))
                    0: frm.push_back(8'd43);
                    1: frm.push_back(8'd92);
                    default: frm.push_back(8'd47);
                endcase
                frm.push_back(8'd10);
            end
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 4))
                    0: v = 8'($urandom);
                    1: v = 8'($urandom_range(64, 90));
                    2: v = 8'($urandom_range(48, 57));
                    3: v = 8'd10;
                    default: v = 8'd43;
                endcase
                pos = $urandom_range(0, frm.size() - 1);
                if ($urandom_range(0, 1) == 1) frm[pos] = v;
                else frm.insert(pos, v);
            end
            if ($urandom_range(0, 11) == 0) begin
                do_restart();
                total++;
                if (obs_flags[1] !== 1'b0 || obs_move !== m_move) begin
                    bad++;
                    $display("FAIL random_restart got=%b/%h want=0/%h", obs_flags[1], obs_move, m_move);
                end
                frm.push_front($urandom_range(0, 1) == 1 ? 8'd66 : 8'd87);
            end
            foreach (frm[i]) begin
                drive_byte(frm[i]);
                total++;
                if ({obs_flags, obs_tail, obs_move} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00, m_move}) begin
                    bad++;
                    $display("FAIL random frame=%0d byte=%h got=%b/%h want=%b/%h", f, frm[i], obs_flags,
                             obs_move, {e_mv, e_fe, m_color_valid, m_color}, m_move);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        string s = "|AA12";
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(xlat(s[i]));
            total++;
            if ({obs_flags, obs_tail} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00}) begin
                bad++;
                $display("FAIL pre_reset byte=%h got=%b want=%b", s[i], obs_flags, {e_mv, e_fe, m_color_valid, m_color});
            end
        end
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        total++;
        if ({move_out, move_valid, color, color_valid, frame_err} !== 26'd0) begin
            bad++;
            $display("FAIL async_reset got=%h want=0", {move_out, move_valid, color, color_valid, frame_err});
        end
        rx_data = 8'd66; rx_finish = 1'b1;
        model_reset();
        @(negedge clock); reset = 1'b1;
        model_byte(8'd66);
        @(posedge clock); #1;
        total++;
        if ({move_valid, frame_err, color_valid, color} !== 4'b0011) begin
            bad++;
            $display("FAIL finish_high_at_release got=%b want=0011", {move_valid, frame_err, color_valid, color});
        end
        @(negedge clock); rx_finish = 1'b0;
        s = "D4/|";
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(xlat(s[i]));
            total++;
            if ({obs_flags, obs_tail, obs_move} !== {e_mv, e_fe, m_color_valid, m_color, 2'b00, m_move}) begin
                bad++;
                $display("FAIL post_reset byte=%h got=%b/%h want=%b/%h", s[i], obs_flags, obs_move,
                         {e_mv, e_fe, m_color_valid, m_color}, m_move);
            end
        end
        total++;
        if (move_out !== {2'b10, 10'd4, 10'd4}) begin
            bad++;
            $display("FAIL move_D4 got=%h want=%h", move_out, {2'b10, 10'd4, 10'd4});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_color();
        test_frames();
        test_errors();
        test_level();
        test_restart();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
